// File: rtl/mult_sequencer_if.sv
// Handshake bundle between the multiply sequencer, pad buttons and the
// shift-add datapath (strobes out, multiplier LSB in).
interface mult_sequencer_if;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_A;
    logic Ld_B;
    logic Add;
    logic Sub;
    logic Shift;
    logic Busy;
    logic Done;

    modport master (
        input  Run,
        input  ClearA_LoadB,
        input  M,
        output Clr_A,
        output Ld_B,
        output Add,
        output Sub,
        output Shift,
        output Busy,
        output Done
    );

    modport slave (
        output Run,
        output ClearA_LoadB,
        output M,
        input  Clr_A,
        input  Ld_B,
        input  Add,
        input  Sub,
        input  Shift,
        input  Busy,
        input  Done
    );
endinterface

// File: rtl/mult_sequencer.sv
// Control FSM for the 8-bit shift-add multiplier datapath.
// Optional MULT_SEQ_AUTOCLR_EN adds a CLRA state so every Run clears A/X.
module mult_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    mult_sequencer_if.master  sif
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef MULT_SEQ_AUTOCLR_EN
    typedef enum logic [2:0] {
        IDLE,
        CLRA,
        ADD,
        SHIFT,
        HOLD
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHIFT,
        HOLD
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SS-1:0] run_q;
    logic [SS-1:0] cl_q;
    logic          run_s;
    logic          cl_s;
    logic          last;

    assign run_s = run_q[SS-1];
    assign cl_s  = cl_q[SS-1];
    assign last  = (cnt == LAST);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            run_q <= '1;
            cl_q  <= '1;
        end else begin
            run_q <= {run_q[SS-2:0], sif.Run};
            cl_q  <= {cl_q[SS-2:0], sif.ClearA_LoadB};
            unique case (state)
                IDLE: begin
                    // Clear/load wins; Run starts only once it reads released
                    if (cl_s && !run_s) begin
                        cnt <= '0;
`ifdef MULT_SEQ_AUTOCLR_EN
                        state <= CLRA;
`else
                        state <= ADD;
`endif
                    end
                end
`ifdef MULT_SEQ_AUTOCLR_EN
                CLRA:  state <= ADD;
`endif
                ADD:   state <= SHIFT;
                SHIFT: begin
                    if (last) begin
                        state <= HOLD;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                HOLD: begin
                    if (run_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic clr_a;
    logic ld_b;
    logic add;
    logic sub;
    logic shift;
    logic busy;
    logic done;

    always_comb begin
        clr_a = 1'b0;
        ld_b  = 1'b0;
        add   = 1'b0;
        sub   = 1'b0;
        shift = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE: begin
                clr_a = ~cl_s;
                ld_b  = ~cl_s;
            end
`ifdef MULT_SEQ_AUTOCLR_EN
            CLRA: begin
                clr_a = 1'b1;
                busy  = 1'b1;
            end
`endif
            // Last multiplier bit is the two's-complement sign: subtract
            ADD: begin
                busy = 1'b1;
                add  = sif.M & ~last;
                sub  = sif.M & last;
            end
            SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                done  = last;
            end
            default: ;
        endcase
    end

    assign sif.Clr_A = clr_a;
    assign sif.Ld_B  = ld_b;
    assign sif.Add   = add;
    assign sif.Sub   = sub;
    assign sif.Shift = shift;
    assign sif.Busy  = busy;
    assign sif.Done  = done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer.
// Expected counts follow the build's MULT_SEQ_AUTOCLR_EN setting.
module tb_mult_sequencer;

`ifdef MULT_SEQ_AUTOCLR_EN
    localparam int AUTOCLR = 1;
`else
    localparam int AUTOCLR = 0;
`endif
    localparam int SYNC = 2;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    mult_sequencer_if sif ();

    mult_sequencer #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .sif   (sif)
    );

    always #10 Clk = ~Clk;

    logic [6:0] outs;
    assign outs = {sif.Clr_A, sif.Ld_B, sif.Add, sif.Sub,
                   sif.Shift, sif.Busy, sif.Done};

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step();
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_c1 outs got %b want %b", outs, 7'b0);
        end
        step();
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_c2 outs got %b want %b", outs, 7'b0);
        end
        Reset = 1'b1;
        step();
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_rel outs got %b want %b", outs, 7'b0);
        end
    endtask

    task automatic test_clear_load();
        int first = -1;
        int cnt = 0;
        int other = 0;
        sif.ClearA_LoadB = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (sif.Clr_A && sif.Ld_B) begin
                cnt++;
                if (first < 0) first = s;
            end
            if (sif.Add || sif.Sub || sif.Shift || sif.Busy || sif.Done)
                other++;
            if (s == 5) sif.ClearA_LoadB = 1'b1;
        end
        checks++;
        if (cnt !== 5) begin
            errors++;
            $display("FAIL clrld_count got %0d want %0d", cnt, 5);
        end
        checks++;
        if (first !== SYNC) begin
            errors++;
            $display("FAIL clrld_latency got %0d want %0d", first, SYNC);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL clrld_other got %0d want %0d", other, 0);
        end
    endtask

    task automatic run_seq(input string nm, input logic [7:0] bits,
                           input int exp_add, input int exp_sub);
        int adds = 0;
        int subs = 0;
        int shifts = 0;
        int busy = 0;
        int dones = 0;
        int clrs = 0;
        int lds = 0;
        int excl = 0;
        int alt = 0;
        int bi = 0;
        int done_at = -1;
        int first_busy = -1;
        sif.M = bits[0];
        sif.Run = 1'b0;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (sif.Busy && first_busy < 0) first_busy = s;
            if ((int'(sif.Add) + int'(sif.Sub) + int'(sif.Shift)) > 1)
                excl++;
            if (sif.Clr_A && (sif.Add || sif.Sub || sif.Shift)) excl++;
            if (sif.Done && !sif.Shift) excl++;
            if (sif.Busy && !sif.Clr_A) begin
                if (int'(sif.Shift) != (bi % 2)) alt++;
                bi++;
            end
            busy += int'(sif.Busy);
            clrs += int'(sif.Clr_A);
            lds  += int'(sif.Ld_B);
            adds += int'(sif.Add);
            subs += int'(sif.Sub);
            if (sif.Shift) begin
                shifts++;
                if (shifts < 8) sif.M = bits[shifts];
            end
            if (sif.Done) begin
                dones++;
                done_at = shifts;
            end
        end
        checks++;
        if (adds !== exp_add) begin
            errors++;
            $display("FAIL %s adds got %0d want %0d", nm, adds, exp_add);
        end
        checks++;
        if (subs !== exp_sub) begin
            errors++;
            $display("FAIL %s subs got %0d want %0d", nm, subs, exp_sub);
        end
        checks++;
        if (shifts !== 8) begin
            errors++;
            $display("FAIL %s shifts got %0d want %0d", nm, shifts, 8);
        end
        checks++;
        if (busy !== 16 + AUTOCLR) begin
            errors++;
            $display("FAIL %s busy got %0d want %0d", nm, busy, 16 + AUTOCLR);
        end
        checks++;
        if (dones !== 1 || done_at !== 8) begin
            errors++;
            $display("FAIL %s done got %0d at shift %0d want 1 at 8",
                     nm, dones, done_at);
        end
        checks++;
        if (clrs !== AUTOCLR || lds !== 0) begin
            errors++;
            $display("FAIL %s clr/ld got %0d/%0d want %0d/0",
                     nm, clrs, lds, AUTOCLR);
        end
        checks++;
        if (excl !== 0 || alt !== 0) begin
            errors++;
            $display("FAIL %s excl/alt got %0d/%0d want 0/0", nm, excl, alt);
        end
        checks++;
        if (first_busy !== SYNC + 1) begin
            errors++;
            $display("FAIL %s start got %0d want %0d", nm, first_busy, SYNC + 1);
        end
        sif.Run = 1'b1;
        repeat (5) step();
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL %s idle outs got %b want %b", nm, outs, 7'b0);
        end
    endtask

    task automatic test_patterns();
        run_seq("ones", 8'hFF, 7, 1);
        run_seq("zeros", 8'h00, 0, 0);
        run_seq("a5", 8'hA5, 3, 1);
        run_seq("signonly", 8'h80, 0, 1);
    endtask

    task automatic test_run_held();
        int shifts = 0;
        int dones = 0;
        sif.M = 1'b1;
        sif.Run = 1'b0;
        for (int s = 1; s <= 100; s++) begin
            step();
            shifts += int'(sif.Shift);
            dones  += int'(sif.Done);
        end
        checks++;
        if (shifts !== 8 || dones !== 1) begin
            errors++;
            $display("FAIL held_once shifts/dones got %0d/%0d want 8/1",
                     shifts, dones);
        end
        checks++;
        if (sif.Busy !== 1'b0) begin
            errors++;
            $display("FAIL held_hold busy got %b want 0", sif.Busy);
        end
        sif.Run = 1'b1;
        repeat (5) step();
        run_seq("second", 8'hFF, 7, 1);
    endtask

    task automatic test_reset_abort();
        int shifts = 0;
        int dones = 0;
        int busy = 0;
        bit hit = 0;
        sif.M = 1'b1;
        sif.Run = 1'b0;
        for (int s = 1; s <= 40 && !hit; s++) begin
            step();
            if (sif.Shift) shifts++;
            if (shifts == 3) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_timeout shifts got %0d want 3", shifts);
        end
        Reset = 1'b0;
        sif.Run = 1'b1;
        step();
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL abort_outs got %b want %b", outs, 7'b0);
        end
        Reset = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            step();
            dones += int'(sif.Done);
            busy  += int'(sif.Busy);
        end
        checks++;
        if (dones !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL abort_after dones/busy got %0d/%0d want 0/0",
                     dones, busy);
        end
    endtask

    task automatic test_both_pressed();
        int clrld = 0;
        int other = 0;
        int lds = 0;
        int shifts = 0;
        int first = -1;
        sif.M = 1'b0;
        sif.Run = 1'b0;
        sif.ClearA_LoadB = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            step();
            clrld += int'(sif.Clr_A && sif.Ld_B);
            other += int'(sif.Add || sif.Sub || sif.Shift || sif.Busy);
        end
        checks++;
        if (clrld !== 7 || other !== 0) begin
            errors++;
            $display("FAIL both_press clrld/other got %0d/%0d want 7/0",
                     clrld, other);
        end
        sif.ClearA_LoadB = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (sif.Busy && first < 0) first = s;
            lds    += int'(sif.Ld_B);
            shifts += int'(sif.Shift);
        end
        checks++;
        if (first !== SYNC + 1) begin
            errors++;
            $display("FAIL both_start got %0d want %0d", first, SYNC + 1);
        end
        checks++;
        if (lds !== 1 || shifts !== 8) begin
            errors++;
            $display("FAIL both_seq ld/shifts got %0d/%0d want 1/8",
                     lds, shifts);
        end
        sif.Run = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        Reset = 1'b0;
        sif.Run = 1'b1;
        sif.ClearA_LoadB = 1'b1;
        sif.M = 1'b0;
        test_reset();
        test_clear_load();
        test_patterns();
        test_run_held();
        test_reset_abort();
        test_both_pressed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
